// File: rtl/arm_multicycle_core.sv
// Multicycle ARMv4-subset core: data-processing, LDR/STR (immediate offset,
// pre-indexed, no writeback, word only) and B/BL with NZCV conditional
// execution. A single memory port with a req/ready handshake serves both
// instruction fetches and data accesses. Interface outputs are registered and
// computed one cycle ahead from the next-state decision.
module arm_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       dbg_pc
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMRD   = 3'd3,
        S_MEMWR   = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    // ARM condition-code evaluation; flags are packed as {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic r;
        case (cond)
            4'h0:    r = f[2];
            4'h1:    r = ~f[2];
            4'h2:    r = f[1];
            4'h3:    r = ~f[1];
            4'h4:    r = f[3];
            4'h5:    r = ~f[3];
            4'h6:    r = f[0];
            4'h7:    r = ~f[0];
            4'h8:    r = f[1] & ~f[2];
            4'h9:    r = ~f[1] | f[2];
            4'hA:    r = (f[3] == f[0]);
            4'hB:    r = (f[3] != f[0]);
            4'hC:    r = ~f[2] & (f[3] == f[0]);
            4'hD:    r = f[2] | (f[3] != f[0]);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // 32-bit rotate right.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] sh);
        logic [63:0] t;
        t = {v, v} >> sh;
        return t[31:0];
    endfunction

    state_t      state_r, state_next_s;
    logic [31:0] pc_r, pc_next_s;
    logic [31:0] ir_r, ir_next_s;
    logic [3:0]  nzcv_r, nzcv_next_s;
    // Entry 15 is never written: R15 reads are redirected to the PC.
    logic [31:0] regs_r [0:15];
    logic [31:0] rn_val_r, rm_val_r, rd_val_r;
    logic [31:0] rn_val_next_s, rm_val_next_s, rd_val_next_s;
    logic [31:0] ea_r, ea_next_s;
    logic [31:0] data_r, data_next_s;
    logic        rf_we_s;
    logic [3:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;
    logic        retire_next_s;

    logic              mem_req_r, mem_we_r, retire_r, halted_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       addr_next_s;

    logic [31:0] rn_read_s, rm_read_s, rd_read_s;
    logic [31:0] op2_s, dp_res_s, ea_calc_s, br_target_s;
    logic [32:0] add_s, sub_s;
    logic        dp_c_s, dp_v_s, dp_cmd_ok_s, is_cmp_s;

    // Register-file read ports; R15 yields the architectural PC (instr addr + 8).
    always_comb begin
        rn_read_s = (ir_r[19:16] == 4'd15) ? pc_r + 32'd4 : regs_r[ir_r[19:16]];
        rm_read_s = (ir_r[3:0]   == 4'd15) ? pc_r + 32'd4 : regs_r[ir_r[3:0]];
        rd_read_s = (ir_r[15:12] == 4'd15) ? pc_r + 32'd4 : regs_r[ir_r[15:12]];
    end

    // Operand 2, adder/subtractor, load/store address and branch target.
    always_comb begin
        op2_s       = ir_r[25] ? ror32({24'h00_0000, ir_r[7:0]}, {ir_r[11:8], 1'b0}) : rm_val_r;
        add_s       = {1'b0, rn_val_r} + {1'b0, op2_s};
        sub_s       = {1'b0, rn_val_r} - {1'b0, op2_s};
        ea_calc_s   = ir_r[23] ? rn_val_r + {20'h0_0000, ir_r[11:0]}
                               : rn_val_r - {20'h0_0000, ir_r[11:0]};
        br_target_s = pc_r + 32'd4 + {{6{ir_r[23]}}, ir_r[23:0], 2'b00};
    end

    // Data-processing result and the C/V flags it produces (AND/ORR/MOV keep C,V).
    always_comb begin
        dp_res_s    = 32'h0000_0000;
        dp_c_s      = nzcv_r[1];
        dp_v_s      = nzcv_r[0];
        dp_cmd_ok_s = 1'b1;
        is_cmp_s    = (ir_r[24:21] == 4'b1010);
        case (ir_r[24:21])
            4'b0000: dp_res_s = rn_val_r & op2_s;
            4'b0010, 4'b1010: begin
                dp_res_s = sub_s[31:0];
                dp_c_s   = ~sub_s[32];
                dp_v_s   = (rn_val_r[31] != op2_s[31]) && (sub_s[31] != rn_val_r[31]);
            end
            4'b0100: begin
                dp_res_s = add_s[31:0];
                dp_c_s   = add_s[32];
                dp_v_s   = (rn_val_r[31] == op2_s[31]) && (add_s[31] != rn_val_r[31]);
            end
            4'b1100: dp_res_s = rn_val_r | op2_s;
            4'b1101: dp_res_s = op2_s;
            default: dp_cmd_ok_s = 1'b0;
        endcase
    end

    // Sequencing FSM: next state, architectural updates and register-file write.
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        ir_next_s     = ir_r;
        nzcv_next_s   = nzcv_r;
        rn_val_next_s = rn_val_r;
        rm_val_next_s = rm_val_r;
        rd_val_next_s = rd_val_r;
        ea_next_s     = ea_r;
        data_next_s   = data_r;
        rf_we_s       = 1'b0;
        rf_waddr_s    = 4'd0;
        rf_wdata_s    = 32'h0000_0000;
        retire_next_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_req_r && mem_ready) begin
                    ir_next_s    = mem_rdata;
                    pc_next_s    = pc_r + 32'd4;
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                rn_val_next_s = rn_read_s;
                rm_val_next_s = rm_read_s;
                rd_val_next_s = rd_read_s;
                if (ir_r[31:28] == 4'hF) begin
                    state_next_s = S_HALT;
                end else if (!cond_pass(ir_r[31:28], nzcv_r)) begin
                    retire_next_s = 1'b1;
                    state_next_s  = S_FETCH;
                end else if ((ir_r[27:26] == 2'b00) || (ir_r[27:26] == 2'b01) ||
                             (ir_r[27:25] == 3'b101)) begin
                    state_next_s = S_EXECUTE;
                end else begin
                    state_next_s = S_HALT;
                end
            end
            S_EXECUTE: begin
                if (ir_r[27:26] == 2'b00) begin
                    if (!dp_cmd_ok_s || (!ir_r[25] && (ir_r[11:4] != 8'h00))) begin
                        state_next_s = S_HALT;
                    end else begin
                        if (is_cmp_s) begin
                            rf_we_s = 1'b0;
                        end else if (ir_r[15:12] == 4'd15) begin
                            pc_next_s = {dp_res_s[31:2], 2'b00};
                        end else begin
                            rf_we_s    = 1'b1;
                            rf_waddr_s = ir_r[15:12];
                            rf_wdata_s = dp_res_s;
                        end
                        if (ir_r[20] || is_cmp_s) begin
                            nzcv_next_s = {dp_res_s[31], (dp_res_s == 32'h0000_0000), dp_c_s, dp_v_s};
                        end else begin
                            nzcv_next_s = nzcv_r;
                        end
                        retire_next_s = 1'b1;
                        state_next_s  = S_FETCH;
                    end
                end else if (ir_r[27:26] == 2'b01) begin
                    // Only pre-indexed, no-writeback, word, immediate-offset forms.
                    if (!ir_r[24] || ir_r[21] || ir_r[22] || ir_r[25] ||
                        (ea_calc_s[1:0] != 2'b00)) begin
                        state_next_s = S_HALT;
                    end else begin
                        ea_next_s    = ea_calc_s;
                        state_next_s = ir_r[20] ? S_MEMRD : S_MEMWR;
                    end
                end else begin
                    pc_next_s = br_target_s;
                    if (ir_r[24]) begin
                        rf_we_s    = 1'b1;
                        rf_waddr_s = 4'd14;
                        rf_wdata_s = pc_r;
                    end else begin
                        rf_we_s = 1'b0;
                    end
                    retire_next_s = 1'b1;
                    state_next_s  = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (mem_req_r && mem_ready) begin
                    data_next_s  = mem_rdata;
                    state_next_s = S_WB;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_req_r && mem_ready) begin
                    retire_next_s = 1'b1;
                    state_next_s  = S_FETCH;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_WB: begin
                if (ir_r[15:12] == 4'd15) begin
                    pc_next_s = {data_r[31:2], 2'b00};
                end else begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = ir_r[15:12];
                    rf_wdata_s = data_r;
                end
                retire_next_s = 1'b1;
                state_next_s  = S_FETCH;
            end
            S_HALT:  state_next_s = S_HALT;
            default: state_next_s = S_HALT;
        endcase
    end

    // Address presented with the next access: PC for fetches, latched EA for data.
    always_comb begin
        case (state_next_s)
            S_FETCH:          addr_next_s = pc_next_s;
            S_MEMRD, S_MEMWR: addr_next_s = ea_next_s;
            default:          addr_next_s = 32'h0000_0000;
        endcase
    end

    // Architectural state, pipeline latches and register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_FETCH;
            pc_r     <= RESET_PC;
            ir_r     <= 32'h0000_0000;
            nzcv_r   <= 4'h0;
            rn_val_r <= 32'h0000_0000;
            rm_val_r <= 32'h0000_0000;
            rd_val_r <= 32'h0000_0000;
            ea_r     <= 32'h0000_0000;
            data_r   <= 32'h0000_0000;
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            ir_r     <= ir_next_s;
            nzcv_r   <= nzcv_next_s;
            rn_val_r <= rn_val_next_s;
            rm_val_r <= rm_val_next_s;
            rd_val_r <= rd_val_next_s;
            ea_r     <= ea_next_s;
            data_r   <= data_next_s;
            if (rf_we_s) begin
                regs_r[rf_waddr_s] <= rf_wdata_s;
            end
        end
    end

    // Registered interface outputs; reset drops any pending request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
            retire_r    <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            mem_req_r   <= (state_next_s == S_FETCH) || (state_next_s == S_MEMRD) ||
                           (state_next_s == S_MEMWR);
            mem_we_r    <= (state_next_s == S_MEMWR);
            mem_addr_r  <= addr_next_s[ADDR_W-1:0];
            mem_wdata_r <= (state_next_s == S_MEMWR) ? rd_val_r : 32'h0000_0000;
            retire_r    <= retire_next_s;
            halted_r    <= (state_next_s == S_HALT);
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign retire    = retire_r;
    assign halted    = halted_r;
    assign dbg_pc    = pc_r;

endmodule

// File: tb/tb_arm_multicycle_core.sv
// Directed bench for arm_multicycle_core: a small program in a bench-side
// memory with programmable ready latency; architectural results, flags,
// bus transactions, retire spacing, halt and reset behaviour are checked.
module tb_arm_multicycle_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_pc;

    logic [31:0] mem [0:63];
    int          wait_cfg  = 0;
    int          stall_cnt = 0;
    int          cyc       = 0;
    int          errors    = 0;
    int          checks    = 0;
    int          retire_q[$];
    logic [31:0] rd_q[$];
    int          wr_count  = 0;
    logic [31:0] last_wr_addr, last_wr_data;
    int          we_stall_cycles = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;

    arm_multicycle_core #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .halted(halted), .dbg_pc(dbg_pc)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && (stall_cnt >= wait_cfg);
    assign mem_rdata = mem_ready ? mem[mem_addr[7:2]] : 32'h0000_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle counter and memory wait-state counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !mem_req || mem_ready) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
    end

    // Bus monitor: log retires, accepted reads/writes, and check stall stability.
    always @(negedge clk) begin
        if (retire) retire_q.push_back(cyc);
        if (mem_req && mem_ready && !mem_we) rd_q.push_back(mem_addr);
        if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
            wr_count++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if (mem_req && !mem_ready && mem_we) we_stall_cycles++;
        if (mem_req && !mem_ready && prev_stall) begin
            check("stall_addr", mem_addr, prev_addr);
            check("stall_we", {31'h0, mem_we}, {31'h0, prev_we});
            check("stall_wdata", mem_wdata, prev_wdata);
        end
        prev_stall = mem_req && !mem_ready;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
    end

    task automatic wait_retires(input int n);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (retire_q.size() >= n) break;
        end
        if (k == 300) check("retire_timeout", retire_q.size(), n);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[0]  = 32'hE3A00005; // 00 MOV  R0,#5
        mem[1]  = 32'hE2801003; // 04 ADD  R1,R0,#3
        mem[2]  = 32'hE0502000; // 08 SUBS R2,R0,R0
        mem[3]  = 32'h12803001; // 0C ADDNE R3,R0,#1
        mem[4]  = 32'hEB000002; // 10 BL   0x20
        mem[5]  = 32'hE3A00008; // 14 MOV  R0,#8
        mem[6]  = 32'hE5801004; // 18 STR  R1,[R0,#4]
        mem[7]  = 32'hEA000000; // 1C B    0x24
        mem[8]  = 32'hE1A0F00E; // 20 MOV  PC,R14
        mem[9]  = 32'hE5904004; // 24 LDR  R4,[R0,#4]
        mem[10] = 32'hE3A06102; // 28 MOV  R6,#0x80000000
        mem[11] = 32'hE2466001; // 2C SUB  R6,R6,#1
        mem[12] = 32'hE2965001; // 30 ADDS R5,R6,#1
        mem[13] = 32'hE0207000; // 34 EOR  R7,R0,R0 (unsupported)

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_retire", {31'h0, retire}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_pc", dbg_pc, 32'h0000_0000);
        rst = 1'b0;

        wait_retires(2);
        check("r1_add", dut.regs_r[1], 32'd8);
        check("int_add", retire_q[1] - retire_q[0], 32'd3);
        check("fetch0", rd_q[0], 32'h00);
        check("fetch1", rd_q[1], 32'h04);

        wait_retires(4);
        check("nzcv_subs", {28'h0, dut.nzcv_r}, 32'h6);
        check("r2_subs", dut.regs_r[2], 32'd0);
        check("r3_condfail", dut.regs_r[3], 32'd0);
        check("int_subs", retire_q[2] - retire_q[1], 32'd3);
        check("int_condfail", retire_q[3] - retire_q[2], 32'd2);

        wait_retires(6);
        check("r14_bl", dut.regs_r[14], 32'h14);
        check("int_bl", retire_q[4] - retire_q[3], 32'd3);
        check("fetch_bl_tgt", rd_q[5], 32'h20);
        check("fetch_ret", rd_q[6], 32'h14);
        @(posedge clk);
        #1 wait_cfg = 3;

        wait_retires(8);
        check("str_count", wr_count, 32'd1);
        check("str_addr", last_wr_addr, 32'd12);
        check("str_data", last_wr_data, 32'd8);
        check("str_we_stall", we_stall_cycles, 32'd3);
        check("int_str", retire_q[7] - retire_q[6], 32'd10);

        wait_retires(10);
        check("r4_ldr", dut.regs_r[4], 32'd8);
        check("ldr_addr", rd_q[10], 32'd12);
        check("int_b", retire_q[8] - retire_q[7], 32'd6);
        check("int_ldr", retire_q[9] - retire_q[8], 32'd11);
        @(posedge clk);
        #1 wait_cfg = 0;

        wait_retires(13);
        check("r6_max", dut.regs_r[6], 32'h7FFF_FFFF);
        check("r5_adds", dut.regs_r[5], 32'h8000_0000);
        check("nzcv_adds", {28'h0, dut.nzcv_r}, 32'h9);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (halted) break;
        end
        check("halted", {31'h0, halted}, 32'h1);
        check("halt_pc", dbg_pc, 32'h38);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halt_req", {31'h0, mem_req}, 32'h0);
            check("halt_sticky", {31'h0, halted}, 32'h1);
        end
        check("halt_noretire", retire_q.size(), 32'd13);

        // Reset abandons a stalled fetch asynchronously.
        wait_cfg = 5;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_halted", {31'h0, halted}, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        check("stall_req", {31'h0, mem_req}, 32'h1);
        check("stall_fetch_addr", mem_addr, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_req_drop", {31'h0, mem_req}, 32'h0);
        check("async_pc", dbg_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_cfg = 0;
        rd_q.delete();
        retire_q.delete();
        wait_retires(1);
        check("resume_fetch", rd_q[0], 32'h00);
        check("resume_r1", dut.regs_r[1], 32'd0);
        check("resume_r0", dut.regs_r[0], 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
